// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline controller (FSM states, slot indices, stall bus width)
package pipe_ctrl_pkg;
  localparam int STALL_BUS_W = 6;
  localparam int SLOT_PC  = 0;
  localparam int SLOT_IF  = 1;
  localparam int SLOT_ID  = 2;
  localparam int SLOT_EX  = 3;
  localparam int SLOT_MEM = 4;
  localparam int SLOT_WB  = 5;
  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_BUSY  = 2'd1,
    MC_DRAIN = 2'd2
  } mc_state_t;
endpackage

// File: rtl/pipe_ctrl_mcfsm.sv
// pipe_ctrl_mcfsm: multi-cycle op FSM (IDLE/BUSY/DRAIN) with timeout counter
//   clk, rst (async, active-low) | mc_start, mc_done, flush_req in
//   mc_busy (BUSY or DRAIN), mc_hold (BUSY: hold issue slot), mc_abort (registered one-cycle pulse)
module pipe_ctrl_mcfsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mc_start,
  input  logic mc_done,
  input  logic flush_req,
  output logic mc_busy,
  output logic mc_hold,
  output logic mc_abort
);
  localparam int CW = $clog2(MC_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MC_TIMEOUT - 1);
  mc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic abort_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MC_IDLE;
      cnt_q    <= '0;
      mc_abort <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_abort <= abort_d;
    end
  end
  // Abort is registered: the pulse appears in the first IDLE cycle after the op is cancelled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        if (mc_start && !flush_req) begin
          state_d = mc_done ? MC_DRAIN : MC_BUSY;
          cnt_d   = '0;
        end
      end
      MC_BUSY: begin
        if (flush_req) begin
          state_d = MC_IDLE;
          abort_d = 1'b1;
        end else if (mc_done) begin
          state_d = MC_DRAIN;
        end else if (cnt_q == LAST) begin
          state_d = MC_IDLE;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MC_DRAIN: state_d = MC_IDLE;
      default:  state_d = MC_IDLE;
    endcase
  end
  assign mc_busy = state_q != MC_IDLE;
  assign mc_hold = state_q == MC_BUSY;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/bubble/flush controller with multi-cycle op tracking
//   clk, rst (async, active-low)
//   stallreq[NSTAGE] per-slot stall requests, mc_start/mc_done multi-cycle handshake, flush_req
//   stall/bubble/flush[NSTAGE] per-slot controls, mc_busy, mc_abort
//   PIPE_CTRL_PERF_EN defined: adds stall_cycles[31:0], saturating count of cycles with stall[0]
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE     = STALL_BUS_W,
  parameter int MC_STAGE   = SLOT_EX,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic              flush_req,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] flush,
  output logic              mc_busy,
  output logic              mc_abort
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  logic mc_hold, kill;
  logic [NSTAGE-1:0] eff, sfx;
  pipe_ctrl_mcfsm #(.MC_TIMEOUT(MC_TIMEOUT)) u_mcfsm (
    .clk      (clk),
    .rst      (rst),
    .mc_start (mc_start),
    .mc_done  (mc_done),
    .flush_req(flush_req),
    .mc_busy  (mc_busy),
    .mc_hold  (mc_hold),
    .mc_abort (mc_abort)
  );
  assign eff = stallreq | (NSTAGE'(mc_hold) << MC_STAGE);
  // sfx[i] is set when any slot at or above i requests a stall, i.e. stall[k:0] for highest k.
  for (genvar i = 0; i < NSTAGE; i++) begin : g_sfx
    assign sfx[i] = |eff[NSTAGE-1:i];
  end
  assign kill   = !rst || flush_req;
  assign stall  = kill ? '0 : sfx;
  // The single slot just above the stalled region receives the bubble.
  assign bubble = kill ? '0 : (sfx << 1) & ~sfx;
  assign flush  = {NSTAGE{kill}};
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cycles <= '0;
    else if (stall[0] && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
  end
`endif
endmodule
